uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Handshaked UART transmitter. Accepts parallel bytes over a valid/ready interface and serialises each into an asynchronous frame: start bit, LSB-first data, optional parity, 1 or 2 stop bits. A one-entry holding register lets a producer queue the next byte during transmission, so frames go out back-to-back with no idle gap. It is the transmit-side companion to the receive path in the UART top level, with its own internal baud timing.

Parameters:
CLKS_PER_BIT, 16, tx_clk cycles per serial bit; legal range >= 2
DATA_BITS, 8, data bits per frame; legal range 5..8
PARITY_EN, 0, 1 = append a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
tx_clk  input  1  transmit clock; all logic is on the rising edge
rst_n  input  1  asynchronous, active-low reset
tx_data  input  DATA_BITS  parallel byte to send; sampled only on acceptance
tx_valid  input  1  producer has a byte on tx_data
tx_ready  output  1  holding register empty; byte accepted when tx_valid & tx_ready
tx_out  output  1  serial line, idles high
tx_busy  output  1  high while a frame is on the line (state != IDLE)
tx_done  output  1  one-cycle pulse when the final stop bit of a frame completes

Behaviour:
- Reset is one clock, tx_clk; rst_n is asynchronous and active-low. While rst_n = 0: tx_out = 1, tx_busy = 0, tx_done = 0, hold_full = 0 (so tx_ready = 1), state = IDLE, baud and bit counters = 0.
- Reset mid-frame: tx_out returns to 1 immediately (asynchronously). The frame in flight and any held byte are discarded.
- tx_ready = !hold_full (combinational from the register).
- Acceptance:
  - tx_valid & tx_ready at edge E0 writes tx_data to the holding register and sets hold_full.
  - Later changes on tx_data have no effect on the queued byte.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE or START.
- Shifter load:
  - In IDLE with hold_full = 1, the next edge E1 copies the holding register into the shifter, clears hold_full and enters START. tx_out goes low after E1.
  - Latency from accepting edge to falling start edge = 1 cycle.
- Simultaneous load and accept: if tx_valid is high on the same edge that the shifter loads from hold, the new byte is accepted (tx_ready was 0 that cycle only if hold_full; see below). hold_full therefore stays or becomes set.
  - Precisely, tx_ready reflects the current hold_full. A load-and-accept on one edge is possible only when the load empties a full register: tx_ready is 0 during that cycle, so no accept occurs.
  - Accept and load never collide; the producer sees tx_ready rise the cycle after the load.
- Bit timing:
  - Each bit (start, data, parity, stop) drives tx_out for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1, and the bit advances when it wraps.
- DATA: bit 0 first, through bit DATA_BITS-1. The bit counter counts 0..DATA_BITS-1.
- PARITY: bit = XOR of the data bits, XOR PARITY_ODD.
- STOP: tx_out = 1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of frame, on the edge completing the last stop bit:
  - tx_done = 1 for exactly the following cycle.
  - If hold_full, the shifter loads and the state goes directly to START, so the next start bit follows with zero idle cycles and tx_busy stays high.
  - Otherwise the state goes to IDLE and tx_busy drops.
- Frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- tx_valid held high while tx_ready = 0 is legal. The byte is simply accepted when tx_ready rises.
- tx_out is registered, with no glitches.

Test Plan:
- Reset, then 0xA5, CLKS_PER_BIT = 16, 8N1: tx_out falls 1 cycle after acceptance. Line carries 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles. tx_done pulses at cycle 160. tx_busy is high for 160 cycles.
- PARITY_EN = 1, PARITY_ODD = 0, byte 0x07: parity bit = 1, frame = 176 cycles. With PARITY_ODD = 1 the parity bit = 0.
- Back-to-back 0x55 then 0xC3, with tx_valid held high:
  - 0xC3 is accepted while 0x55 is on the line, and tx_ready drops.
  - 0xC3's start bit begins the cycle after 0x55's stop bit ends, with zero gap.
  - Two tx_done pulses, 160 cycles apart.
- Third byte offered while both the shifter and the hold are occupied: tx_ready = 0, nothing is accepted. Acceptance happens exactly 1 cycle after the second frame loads.
- rst_n pulsed low mid-DATA of 0xFF with a held byte pending: tx_out = 1 asynchronously, tx_ready = 1, tx_busy = 0, no tx_done. No frame appears after reset release without a new tx_valid.
- STOP_BITS = 2, DATA_BITS = 7, byte 0x41: stop high for 32 cycles, frame = 160 cycles.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if
//
// Byte handshake between a producer and the UART transmitter.
//
//   tx_data   producer -> transmitter  byte to send, sampled on acceptance
//   tx_valid  producer -> transmitter  a byte is present on tx_data
//   tx_ready  transmitter -> producer  holding register empty
//
// A byte moves on any rising clock edge where tx_valid & tx_ready.
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  // Producer side drives data/valid and watches ready
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Transmitter side consumes data/valid and drives ready
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Handshaked UART transmitter. Bytes arrive over a valid/ready interface
// into a one-entry holding register and are serialised as
//   start(0), data LSB first, optional parity, 1 or 2 stop bits(1).
// A byte queued in the holding register is loaded on the very edge that
// completes the previous frame's last stop bit, so frames run back-to-back.
//
// Ports
//   tx_clk   transmit clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      slave side of uart_tx_ctrl_if (tx_data, tx_valid, tx_ready)
//   tx_out   registered serial line, idles high
//   tx_busy  high while a frame is on the line
//   tx_done  one-cycle pulse after the final stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 tx_clk,
  input  logic                 rst_n,
  uart_tx_ctrl_if.slave        bus,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int             BaudWidth    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudWidth-1:0] BaudLast = BaudWidth'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     DataLast     = 3'(DATA_BITS - 1);
  localparam logic [2:0]     StopLast     = 3'(STOP_BITS - 1);
  localparam logic           ParityOddBit = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                 state_q,    state_d;
  logic [BaudWidth-1:0]   baudCnt_q,  baudCnt_d;
  logic [2:0]             bitCnt_q,   bitCnt_d;
  logic [DATA_BITS-1:0]   shift_q,    shift_d;
  logic [DATA_BITS-1:0]   hold_q,     hold_d;
  logic                   holdFull_q, holdFull_d;
  logic                   parity_q,   parity_d;
  logic                   txOut_q,    txOut_d;
  logic                   txDone_q,   txDone_d;
  logic                   baudWrap;
  logic                   loadShift;

  // State register. Reset forces the line high straight away and throws
  // away both the frame in flight and any byte waiting in the hold.
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baudCnt_q  <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      parity_q   <= 1'b0;
      txOut_q    <= 1'b1;
      txDone_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baudCnt_q  <= baudCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
      parity_q   <= parity_d;
      txOut_q    <= txOut_d;
      txDone_q   <= txDone_d;
    end
  end

  // Next-state logic. The line value for the coming cycle is decided here
  // together with the state change, so tx_out comes straight off a flop.
  // The shifter keeps the current data bit in position 0; shift_q[1] is
  // therefore the bit that goes out next.
  always_comb begin
    state_d    = state_q;
    baudCnt_d  = '0;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    parity_d   = parity_q;
    txOut_d    = txOut_q;
    txDone_d   = 1'b0;
    loadShift  = 1'b0;
    baudWrap   = (baudCnt_q == BaudLast);

    if (state_q != IDLE) begin
      baudCnt_d = baudWrap ? '0 : baudCnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (holdFull_q) begin
          loadShift = 1'b1;
        end
      end
      START: begin
        if (baudWrap) begin
          state_d  = DATA;
          bitCnt_d = '0;
          txOut_d  = shift_q[0];
        end
      end
      DATA: begin
        if (baudWrap) begin
          if (bitCnt_q == DataLast) begin
            bitCnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              txOut_d = parity_q;
            end else begin
              state_d = STOP;
              txOut_d = 1'b1;
            end
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
            shift_d  = shift_q >> 1;
            txOut_d  = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (baudWrap) begin
          state_d  = STOP;
          bitCnt_d = '0;
          txOut_d  = 1'b1;
        end
      end
      STOP: begin
        if (baudWrap) begin
          if (bitCnt_q == StopLast) begin
            txDone_d = 1'b1;
            if (holdFull_q) begin
              loadShift = 1'b1;
            end else begin
              state_d = IDLE;
              txOut_d = 1'b1;
            end
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txOut_d = 1'b1;
      end
    endcase

    // Moving the held byte into the shifter starts a new frame. Parity is
    // worked out once here rather than accumulated bit by bit.
    if (loadShift) begin
      state_d    = START;
      baudCnt_d  = '0;
      bitCnt_d   = '0;
      shift_d    = hold_q;
      parity_d   = (^hold_q) ^ ParityOddBit;
      holdFull_d = 1'b0;
      txOut_d    = 1'b0;
    end

    // Acceptance only happens with the hold empty, and a load only happens
    // with it full, so the two can never land on the same edge.
    if (bus.tx_valid && !holdFull_q) begin
      hold_d     = bus.tx_data;
      holdFull_d = 1'b1;
    end
  end

  assign bus.tx_ready = ~holdFull_q;
  assign tx_out       = txOut_q;
  assign tx_done      = txDone_q;
  assign tx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Directed bench for uart_tx_ctrl. Four instances share clock and reset:
//   A: 8N1   B: 8E1   C: 8O1   D: 7N2   (all 16 clocks per bit)
// Frames are written out by hand as {stop(s), parity, data, start} so bit
// i of the vector is the i-th bit on the line.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dataW [4];
  logic [3:0] validV;

  logic outA, outB, outC, outD;
  logic busyA, busyB, busyC, busyD;
  logic doneA, doneB, doneC, doneD;

  logic [3:0] txOutV, busyV, doneV, readyV;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  uart_tx_ctrl_if #(.DATA_BITS(8)) busA ();
  uart_tx_ctrl_if #(.DATA_BITS(8)) busB ();
  uart_tx_ctrl_if #(.DATA_BITS(8)) busC ();
  uart_tx_ctrl_if #(.DATA_BITS(7)) busD ();

  assign busA.tx_data  = dataW[0];
  assign busB.tx_data  = dataW[1];
  assign busC.tx_data  = dataW[2];
  assign busD.tx_data  = dataW[3][6:0];
  assign busA.tx_valid = validV[0];
  assign busB.tx_valid = validV[1];
  assign busC.tx_valid = validV[2];
  assign busD.tx_valid = validV[3];

  assign txOutV = {outD, outC, outB, outA};
  assign busyV  = {busyD, busyC, busyB, busyA};
  assign doneV  = {doneD, doneC, doneB, doneA};
  assign readyV = {busD.tx_ready, busC.tx_ready, busB.tx_ready, busA.tx_ready};

  uart_tx_ctrl #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dutA (.tx_clk(clk), .rst_n(rst_n), .bus(busA), .tx_out(outA), .tx_busy(busyA), .tx_done(doneA));
  uart_tx_ctrl #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dutB (.tx_clk(clk), .rst_n(rst_n), .bus(busB), .tx_out(outB), .tx_busy(busyB), .tx_done(doneB));
  uart_tx_ctrl #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    dutC (.tx_clk(clk), .rst_n(rst_n), .bus(busC), .tx_out(outC), .tx_busy(busyC), .tx_done(doneC));
  uart_tx_ctrl #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    dutD (.tx_clk(clk), .rst_n(rst_n), .bus(busD), .tx_out(outD), .tx_busy(busyD), .tx_done(doneD));

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one producer's data/valid
  task automatic applyStimulus(input int w, input logic [7:0] data, input logic valid);
    dataW[w]  = data;
    validV[w] = valid;
  endtask

  // One comparison
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Walk a frame cycle by cycle from startCycle to its end, then check the
  // edge that completes the last stop bit. chained means a held byte should
  // be loaded on that edge so the next start bit follows immediately.
  task automatic checkFrame(input string tag, input int w, input logic [11:0] bits,
                            input int nBits, input int startCycle,
                            input logic expReady, input logic chained);
    for (int i = startCycle; i < nBits * 16; i++) begin
      checkOutput({tag, " line"},  32'(txOutV[w]), 32'(bits[i / 16]));
      checkOutput({tag, " busy"},  32'(busyV[w]),  32'd1);
      checkOutput({tag, " done"},  32'(doneV[w]),  32'd0);
      checkOutput({tag, " ready"}, 32'(readyV[w]), 32'(expReady));
      tick(1);
    end
    checkOutput({tag, " end done"},  32'(doneV[w]),  32'd1);
    checkOutput({tag, " end busy"},  32'(busyV[w]),  32'(chained));
    checkOutput({tag, " end line"},  32'(txOutV[w]), 32'(!chained));
    checkOutput({tag, " end ready"}, 32'(readyV[w]), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(i, 8'h00, 1'b0);

    // Reset state
    tick(2);
    checkOutput("rst line A",  32'(outA), 32'd1);
    checkOutput("rst busy A",  32'(busyA), 32'd0);
    checkOutput("rst done A",  32'(doneA), 32'd0);
    checkOutput("rst ready A", 32'(busA.tx_ready), 32'd1);
    checkOutput("rst line D",  32'(outD), 32'd1);
    checkOutput("rst ready D", 32'(busD.tx_ready), 32'd1);
    rst_n = 1'b1;
    tick(2);

    // 0xA5 on 8N1: accept, then start bit one edge later
    applyStimulus(0, 8'hA5, 1'b1);
    tick(1);
    checkOutput("a5 ready after accept", 32'(busA.tx_ready), 32'd0);
    checkOutput("a5 line before load",   32'(outA), 32'd1);
    checkOutput("a5 busy before load",   32'(busyA), 32'd0);
    applyStimulus(0, 8'h00, 1'b0);
    tick(1);
    checkFrame("a5", 0, 12'b00_1_10100101_0, 10, 0, 1'b1, 1'b0);
    tick(1);
    checkOutput("a5 done drops", 32'(doneA), 32'd0);

    // 0x07 with even parity: parity bit 1, 176-cycle frame
    applyStimulus(1, 8'h07, 1'b1);
    tick(1);
    applyStimulus(1, 8'h00, 1'b0);
    tick(1);
    checkFrame("even07", 1, 12'b0_1_1_00000111_0, 11, 0, 1'b1, 1'b0);

    // 0x07 with odd parity: parity bit 0
    applyStimulus(2, 8'h07, 1'b1);
    tick(1);
    applyStimulus(2, 8'h00, 1'b0);
    tick(1);
    checkFrame("odd07", 2, 12'b0_1_0_00000111_0, 11, 0, 1'b1, 1'b0);

    // 0x41 on 7N2: two stop bits, 160-cycle frame
    applyStimulus(3, 8'h41, 1'b1);
    tick(1);
    applyStimulus(3, 8'h00, 1'b0);
    tick(1);
    checkFrame("7n2 41", 3, 12'b00_11_1000001_0, 10, 0, 1'b1, 1'b0);

    // Back-to-back 0x55, 0xC3 with valid held, 0x3C offered while full
    applyStimulus(0, 8'h55, 1'b1);
    tick(1);
    checkOutput("b2b ready after 55", 32'(busA.tx_ready), 32'd0);
    applyStimulus(0, 8'hC3, 1'b1);
    tick(1);
    checkOutput("b2b 55 start", 32'(outA), 32'd0);
    checkOutput("b2b ready after load", 32'(busA.tx_ready), 32'd1);
    tick(1);
    checkOutput("b2b c3 accepted", 32'(busA.tx_ready), 32'd0);
    applyStimulus(0, 8'h3C, 1'b1);
    checkFrame("b2b 55", 0, 12'b00_1_01010101_0, 10, 1, 1'b0, 1'b1);
    tick(1);
    checkOutput("b2b 3c accepted", 32'(busA.tx_ready), 32'd0);
    checkOutput("b2b done one cycle", 32'(doneA), 32'd0);
    applyStimulus(0, 8'h00, 1'b0);
    checkFrame("b2b c3", 0, 12'b00_1_11000011_0, 10, 1, 1'b0, 1'b1);
    tick(1);
    checkFrame("b2b 3c", 0, 12'b00_1_00111100_0, 10, 1, 1'b1, 1'b0);
    tick(1);

    // Reset mid-DATA of 0xFF with 0x12 waiting in the hold
    applyStimulus(0, 8'hFF, 1'b1);
    tick(1);
    applyStimulus(0, 8'h12, 1'b1);
    tick(1);
    tick(1);
    applyStimulus(0, 8'h00, 1'b0);
    tick(30);
    checkOutput("ff busy mid data",  32'(busyA), 32'd1);
    checkOutput("ff ready mid data", 32'(busA.tx_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ff rst line",  32'(outA), 32'd1);
    checkOutput("ff rst ready", 32'(busA.tx_ready), 32'd1);
    checkOutput("ff rst busy",  32'(busyA), 32'd0);
    checkOutput("ff rst done",  32'(doneA), 32'd0);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      checkOutput("post rst line", 32'(outA), 32'd1);
      checkOutput("post rst busy", 32'(busyA), 32'd0);
      checkOutput("post rst done", 32'(doneA), 32'd0);
    end

    // Reset during a start bit pulls the line high without waiting for a clock
    applyStimulus(0, 8'h5A, 1'b1);
    tick(1);
    applyStimulus(0, 8'h00, 1'b0);
    tick(1);
    checkOutput("5a start low", 32'(outA), 32'd0);
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("5a async line", 32'(outA), 32'd1);
    checkOutput("5a async busy", 32'(busyA), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    checkOutput("5a after rst line", 32'(outA), 32'd1);
    checkOutput("5a after rst busy", 32'(busyA), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
